// File: rtl/lenet_pkg.sv
// rtl/lenet_pkg.sv - shared LeNet widths, layer map sizes and reader state encoding
package lenet_pkg;

    localparam int DATA_WIDTH = 16;

    localparam int FC1_OUT = 120;
    localparam int FC2_OUT = 84;
    localparam int FC3_OUT = 10;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_READ_ENC  = 2'd1;
    localparam logic [1:0] ST_DRAIN_ENC = 2'd2;
    localparam logic [1:0] ST_DONE_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_READ  = ST_READ_ENC,
        ST_DRAIN = ST_DRAIN_ENC,
        ST_DONE  = ST_DONE_ENC
    } reader_state_t;

endpackage

// File: rtl/fc_skid_fifo.sv
// rtl/fc_skid_fifo.sv - two-entry skid FIFO of {index, data, last} for the result stream
module fc_skid_fifo
    import lenet_pkg::*;
#(
    parameter int DW = DATA_WIDTH,
    parameter int AW = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 push,
    input  logic [AW-1:0]        push_index,
    input  logic signed [DW-1:0] push_data,
    input  logic                 push_last,
    input  logic                 pop,
    output logic [1:0]           count,
    output logic                 head_valid,
    output logic [AW-1:0]        head_index,
    output logic signed [DW-1:0] head_data,
    output logic                 head_last
);

    logic [AW-1:0]        idx_mem  [2];
    logic signed [DW-1:0] data_mem [2];
    logic [1:0]           last_mem;
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            last_mem <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                idx_mem[i]  <= '0;
                data_mem[i] <= '0;
            end
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (do_push) begin
                idx_mem[wr_ptr]  <= push_index;
                data_mem[wr_ptr] <= push_data;
                last_mem[wr_ptr] <= push_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign head_valid = (count != 2'd0);
    assign head_index = idx_mem[rd_ptr];
    assign head_data  = data_mem[rd_ptr];
    assign head_last  = last_mem[rd_ptr];

endmodule

// File: rtl/fc_result_reader.sv
// rtl/fc_result_reader.sv - drains an FC output buffer as a stream and tracks signed argmax
module fc_result_reader
    import lenet_pkg::*;
#(
    parameter int DATA_WIDTH = lenet_pkg::DATA_WIDTH,
    parameter int OUT_MAP    = FC2_OUT,
    parameter int ADDR_WIDTH = 7,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic [ADDR_WIDTH-1:0]        rd_addr,
    output logic                         rd_en,
    input  logic signed [DATA_WIDTH-1:0] rd_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0]        out_index,
    output logic                         out_last,
    output logic [ADDR_WIDTH-1:0]        max_index,
    output logic signed [DATA_WIDTH-1:0] max_value,
    output logic                         done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(OUT_MAP - 1);

    reader_state_t               state;
    logic                        start_d;
    logic                        rd_pending;
    logic [ADDR_WIDTH-1:0]       pend_addr;
    logic [1:0]                  fifo_count;
    logic                        fifo_valid;
    logic [ADDR_WIDTH-1:0]       fifo_index;
    logic signed [DATA_WIDTH-1:0] fifo_data;
    logic                        fifo_last;
    logic                        pop;
    logic                        abort;
    logic                        credit_ok;

    assign pop   = fifo_valid && out_ready;
    assign abort = !start && ((state == ST_READ) || (state == ST_DRAIN));

    // Credit counts the word on rd_data that lands next edge; the read strobe is
    // combinational so a two-deep FIFO still sustains one word per cycle.
    assign credit_ok = ({1'b0, fifo_count} + {2'b00, rd_pending} - {2'b00, pop})
                       < 3'(BUF_DEPTH);
    assign rd_en     = (state == ST_READ) && start && credit_ok;

    fc_skid_fifo #(
        .DW (DATA_WIDTH),
        .AW (ADDR_WIDTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (abort),
        .push       (rd_pending),
        .push_index (pend_addr),
        .push_data  (rd_data),
        .push_last  (pend_addr == LAST_ADDR),
        .pop        (pop),
        .count      (fifo_count),
        .head_valid (fifo_valid),
        .head_index (fifo_index),
        .head_data  (fifo_data),
        .head_last  (fifo_last)
    );

    assign out_valid = fifo_valid;
    assign out_data  = fifo_data;
    assign out_index = fifo_index;
    assign out_last  = fifo_last;

    always_ff @(posedge clk) begin
        // Follows start through reset so a level held across reset cannot retrigger.
        start_d <= start;
        if (rst) begin
            state      <= ST_IDLE;
            rd_addr    <= '0;
            rd_pending <= 1'b0;
            pend_addr  <= '0;
            done       <= 1'b0;
            max_index  <= '0;
            max_value  <= '0;
        end else begin
            rd_pending <= rd_en;
            pend_addr  <= rd_addr;
            case (state)
                ST_IDLE: begin
                    if (start && !start_d) begin
                        state     <= ST_READ;
                        rd_addr   <= '0;
                        done      <= 1'b0;
                        max_index <= '0;
                        max_value <= '0;
                    end
                end
                ST_READ: begin
                    if (!start) begin
                        state     <= ST_IDLE;
                        rd_addr   <= '0;
                        max_index <= '0;
                        max_value <= '0;
                    end else if (rd_en) begin
                        if (rd_addr == LAST_ADDR) begin
                            state <= ST_DRAIN;
                        end else begin
                            rd_addr <= rd_addr + ADDR_WIDTH'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!start) begin
                        state     <= ST_IDLE;
                        rd_addr   <= '0;
                        max_index <= '0;
                        max_value <= '0;
                    end else if (pop && fifo_last) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!start) begin
                        state <= ST_IDLE;
                        done  <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Index 0 seeds the tracker; strict compare keeps the lowest index on ties.
            if (pop && !abort) begin
                if ((fifo_index == '0) || (fifo_data > max_value)) begin
                    max_value <= fifo_data;
                    max_index <= fifo_index;
                end
            end
        end
    end

endmodule

// File: doc/fc_result_reader.md
Name: fc_result_reader

Overview:
- Drains a fully-connected layer's output buffer after that layer signals completion.
- Reads OUT_MAP words from the shared output RAM (synchronous read, 1-cycle latency) and presents them in index order as a valid/ready stream for the next layer.
- Tracks signed argmax across the stream; this serves the classifier stage.
- Sits between the FC layer's FC_done and the following layer's input loader.

Parameters:
DATA_WIDTH, 16, signed word width of buffer entries
OUT_MAP, 84, number of entries to read (indices 0..OUT_MAP-1)
ADDR_WIDTH, 7, output-buffer address width; OUT_MAP <= 2**ADDR_WIDTH
BUF_DEPTH, 2, internal skid FIFO depth (fixed at 2)

Ports:
clk, input, 1, system clock
rst, input, 1, synchronous active-high reset
start, input, 1, level; FC_done from the producing FC layer
rd_addr, output, ADDR_WIDTH, output-buffer read address
rd_en, output, 1, read strobe; data appears on rd_data the next cycle
rd_data, input signed, DATA_WIDTH, buffer read data
out_valid, output, 1, stream word valid
out_ready, input, 1, downstream accepts
out_data, output signed, DATA_WIDTH, stream word
out_index, output, ADDR_WIDTH, buffer index of out_data
out_last, output, 1, high with index OUT_MAP-1
max_index, output, ADDR_WIDTH, index of largest value; valid when done=1
max_value, output signed, DATA_WIDTH, largest value; valid when done=1
done, output, 1, all words accepted downstream

Behaviour:
- Reset (rst=1 at posedge): state IDLE. rd_addr, rd_en, out_valid, out_data, out_index, out_last, done, max_index and max_value all 0. FIFO emptied, in-flight read discarded.
- States: IDLE, READ, DRAIN, DONE.
- IDLE -> READ: on rising edge of start (start=1, registered start_d=0). start held high from a previous run does not retrigger.
- READ: issue rd_en with rd_addr = 0,1,2,... while (fifo_count + inflight - pop) < BUF_DEPTH. After issuing OUT_MAP-1 -> DRAIN.
- DRAIN: no further reads. Leave when the FIFO is empty and the word with out_last has handshaken -> DONE.
- DONE: done=1 and max_* frozen. Return to IDLE when start=0.
- Abort: start=0 in READ or DRAIN -> IDLE next cycle. FIFO flushed, out_valid=0, done stays 0, argmax cleared.
- Read return: rd_data captured into the FIFO the cycle after rd_en, tagged with its address. No word may be lost or duplicated under any out_ready pattern.
- Stream rules:
  - Transfer when out_valid & out_ready.
  - While out_valid=1 and out_ready=0, out_data/out_index/out_last hold stable.
  - out_valid never drops without a transfer, except on rst or abort.
- Throughput: with out_ready held 1, first out_valid 2 cycles after the start edge, then 1 word/cycle. OUT_MAP words take OUT_MAP+2 cycles from start edge to last transfer. done rises the cycle after the last transfer.
- Argmax:
  - Updated on each transfer using signed compare, strict greater-than, so the lowest index wins ties.
  - Seeded by the index-0 word.
  - For all-equal data, max_index=0.
- Address stays within 0..OUT_MAP-1; rd_addr holds its last value after issuing OUT_MAP-1.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged.

Decomposition:
- Shared package (lenet_pkg):
  - DATA_WIDTH
  - per-layer map sizes (FC1_OUT=120, FC2_OUT=84, FC3_OUT=10)
  - state encoding localparams for IDLE/READ/DRAIN/DONE
- One sub-module: fc_skid_fifo, a 2-entry FIFO of {index, data, last} with push/pop/count, so the credit logic stays separate from the FSM.
- Argmax tracker stays inline.

Test Plan:
- Buffer preloaded with value[i]=i-40, start pulses high, out_ready=1 -> 84 words, indices 0..83, data -40..43; out_last only at 83; done 1 cycle after; max_index=83, max_value=43.
- Same data, out_ready toggling 1,0,0,1 repeating -> same 84-word sequence with no drops or duplicates; data stable while stalled; done still reached.
- Data all 0x0005 except index 17=0x7FFF and index 60=0x7FFF -> max_index=17, max_value=32767. Negatives tested with all 0x8000 except index 5=0xFFFF -> max_index=5.
- start dropped after 30 transfers -> next cycle IDLE with out_valid=0; re-raise start -> restart from index 0.
- rst asserted in DRAIN with out_valid=1, out_ready=0 -> next cycle all outputs 0 and state IDLE; start held high across reset produces no transfer until a fresh rising edge.
- Parameter run OUT_MAP=10 -> exactly 10 transfers; rd_addr never exceeds 9.
